// File: rtl/cruise_pkg.sv
// cruise_pkg: shared state encoding and default speed limits for the cruise controller
package cruise_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        ACTIVE  = 2'd2,
        SUSPEND = 2'd3
    } state_e;
    localparam int MIN_SPEED_DEF  = 30;
    localparam int MAX_SPEED_DEF  = 200;
    localparam int STEP_DEF       = 2;
    localparam int CMP_PERIOD_DEF = 4;
endpackage

// File: rtl/sample_timer.sv
// sample_timer: counts 0..PERIOD-1 while run is high and flags the last count as a sample point
module sample_timer #(
    parameter int PERIOD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic tick
);
    logic [7:0] cnt_q, cnt_d;
    always_comb begin
        tick  = run && cnt_q == 8'(PERIOD - 1);
        cnt_d = (clear || !run || tick) ? 8'd0 : cnt_q + 8'd1;
    end
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= 8'd0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/cruise_speed_controller.sv
// cruise_speed_controller: cruise FSM holding a target speed and pulsing throttle from an external comparator
module cruise_speed_controller
    import cruise_pkg::*;
#(
    parameter int MIN_SPEED  = MIN_SPEED_DEF,
    parameter int MAX_SPEED  = MAX_SPEED_DEF,
    parameter int STEP       = STEP_DEF,
    parameter int CMP_PERIOD = CMP_PERIOD_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cruise_on,
    input  logic       set_btn,
    input  logic       resume_btn,
    input  logic       inc_btn,
    input  logic       dec_btn,
    input  logic       brake,
    input  logic [7:0] speed,
    output logic [7:0] target,
    output logic       cmp_en,
    input  logic       cmp_g,
    input  logic       cmp_eq,
    input  logic       cmp_l,
    output logic       throttle_up,
    output logic       throttle_down,
    output logic [1:0] state,
    output logic       fault
);
    state_e     state_q, state_d;
    logic [7:0] target_q, target_d, tgt_step;
    logic [8:0] inc_sum;
    logic       up_q, up_d, down_q, down_d, fault_q, fault_d;
    logic       tick, clear, set_ok, act, bad;

    sample_timer #(.PERIOD(CMP_PERIOD)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .run   (state_q == ACTIVE),
        .tick  (tick)
    );

    always_comb begin
        inc_sum  = {1'b0, target_q} + 9'(STEP);
        set_ok   = set_btn && speed >= 8'(MIN_SPEED) && speed <= 8'(MAX_SPEED);
        tgt_step = inc_btn ? (inc_sum > 9'(MAX_SPEED) ? 8'(MAX_SPEED) : inc_sum[7:0])
                           : (target_q >= 8'(MIN_SPEED + STEP) ? target_q - 8'(STEP) : 8'(MIN_SPEED));
        state_d  = state_q;
        target_d = target_q;
        act      = 1'b1;
        bad      = 1'b0;
        up_d     = 1'b0;
        down_d   = 1'b0;
        if (brake && state_q == ACTIVE) state_d = SUSPEND;
        else if (!cruise_on) state_d = IDLE;
        else if (state_q == IDLE) state_d = ARMED;
        else if (set_ok) begin
            state_d  = ACTIVE;
            target_d = speed;
        end
        else if (resume_btn && state_q == SUSPEND) state_d = ACTIVE;
        else if (state_q == ACTIVE && (inc_btn ^ dec_btn) && tgt_step != target_q) target_d = tgt_step;
        else begin
            // only an undisturbed ACTIVE cycle at the sample point reads the comparator
            act    = 1'b0;
            bad    = tick && !$onehot({cmp_g, cmp_eq, cmp_l});
            up_d   = tick && !bad && cmp_l;
            down_d = tick && !bad && cmp_g;
            if (bad) state_d = SUSPEND;
        end
        clear   = act || bad || state_q != ACTIVE;
        fault_d = state_d != IDLE && (fault_q || bad);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            target_q <= 8'd0;
            up_q     <= 1'b0;
            down_q   <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            up_q     <= up_d;
            down_q   <= down_d;
            fault_q  <= fault_d;
        end
    end

    assign target        = target_q;
    assign cmp_en        = state_q == ACTIVE;
    assign throttle_up   = up_q;
    assign throttle_down = down_q;
    assign state         = state_q;
    assign fault         = fault_q;
endmodule

// File: tb/tb_cruise_speed_controller.sv
// tb_cruise_speed_controller: table vectors, corner sequences and a randomized run against a reference model
module tb_cruise_speed_controller;
    localparam int MIN = 30;
    localparam int MAX = 200;
    localparam int STP = 2;
    localparam int PER = 4;

    logic       clk = 1'b0;
    logic       rst, cruise_on, set_btn, resume_btn, inc_btn, dec_btn, brake;
    logic       cmp_g, cmp_eq, cmp_l;
    logic [7:0] speed, target;
    logic       cmp_en, throttle_up, throttle_down, fault;
    logic [1:0] state;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        logic co, set, res, inc, dec, brk;
        int   spd;
        logic bad;
        int   st, tgt;
        logic up, dn, flt;
    } vec_t;
    vec_t tv[$];

    int m_st, m_tgt, m_age;
    bit m_up, m_dn, m_flt;

    always #5 clk = ~clk;

    cruise_speed_controller dut (
        .clk           (clk),
        .rst           (rst),
        .cruise_on     (cruise_on),
        .set_btn       (set_btn),
        .resume_btn    (resume_btn),
        .inc_btn       (inc_btn),
        .dec_btn       (dec_btn),
        .brake         (brake),
        .speed         (speed),
        .target        (target),
        .cmp_en        (cmp_en),
        .cmp_g         (cmp_g),
        .cmp_eq        (cmp_eq),
        .cmp_l         (cmp_l),
        .throttle_up   (throttle_up),
        .throttle_down (throttle_down),
        .state         (state),
        .fault         (fault)
    );

    function automatic void add(logic co, logic set, logic res, logic inc, logic dec, logic brk, int spd,
                                logic bad, int st, int tgt, logic up, logic dn, logic flt);
        vec_t v;
        v.co = co; v.set = set; v.res = res; v.inc = inc; v.dec = dec; v.brk = brk;
        v.spd = spd; v.bad = bad; v.st = st; v.tgt = tgt; v.up = up; v.dn = dn; v.flt = flt;
        tv.push_back(v);
    endfunction

    task automatic chk(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_all(string tag, int st, int tgt, bit up, bit dn, bit flt);
        chk({tag, ".state"}, int'(state), st);
        chk({tag, ".target"}, int'(target), tgt);
        chk({tag, ".cmp_en"}, int'(cmp_en), int'(st == 2));
        chk({tag, ".up"}, int'(throttle_up), int'(up));
        chk({tag, ".down"}, int'(throttle_down), int'(dn));
        chk({tag, ".fault"}, int'(fault), int'(flt));
    endtask

    // external comparator: compares speed with the expected target, optionally corrupted
    task automatic drive_cmp(int tg, bit corrupt);
        if (corrupt) begin
            case ($urandom % 5)
                0: {cmp_g, cmp_eq, cmp_l} = 3'b000;
                1: {cmp_g, cmp_eq, cmp_l} = 3'b011;
                2: {cmp_g, cmp_eq, cmp_l} = 3'b101;
                3: {cmp_g, cmp_eq, cmp_l} = 3'b110;
                default: {cmp_g, cmp_eq, cmp_l} = 3'b111;
            endcase
        end else begin
            cmp_g  = int'(speed) > tg;
            cmp_eq = int'(speed) == tg;
            cmp_l  = int'(speed) < tg;
        end
    endtask

    task automatic drive(bit co, bit set, bit res, bit inc, bit dec, bit brk, int spd, int tg);
        cruise_on = co; set_btn = set; resume_btn = res; inc_btn = inc; dec_btn = dec; brake = brk;
        speed = 8'(spd);
        drive_cmp(tg, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        rst = 1'b0;
    endtask

    task automatic model_step();
        int  nst, ntgt, cand;
        bit  act, restart;
        m_up = 0;
        m_dn = 0;
        if (rst) begin
            m_st = 0; m_tgt = 0; m_age = 0; m_flt = 0;
            return;
        end
        nst = m_st; ntgt = m_tgt; act = 1; restart = 0;
        cand = inc_btn ? ((m_tgt + STP > MAX) ? MAX : m_tgt + STP) : ((m_tgt - STP < MIN) ? MIN : m_tgt - STP);
        if (brake && m_st == 2) nst = 3;
        else if (!cruise_on) nst = 0;
        else if (m_st == 0) nst = 1;
        else if (set_btn && int'(speed) >= MIN && int'(speed) <= MAX) begin
            nst = 2; ntgt = int'(speed); restart = 1;
        end
        else if (resume_btn && m_st == 3) nst = 2;
        else if (m_st == 2 && inc_btn != dec_btn && cand != m_tgt) begin
            ntgt = cand; restart = 1;
        end
        else act = 0;
        if (!act && m_st == 2 && m_age % PER == PER - 1) begin
            if (int'(cmp_g) + int'(cmp_eq) + int'(cmp_l) != 1) begin
                m_flt = 1; nst = 3;
            end else begin
                m_up = cmp_l; m_dn = cmp_g;
            end
        end
        m_age = (nst == 2 && m_st == 2 && !restart) ? m_age + 1 : 0;
        if (nst == 0) m_flt = 0;
        m_st = nst;
        m_tgt = ntgt;
    endtask

    initial begin
        int cur_tgt, ups, dns, first_up, last_up, gap_ok;
        //   co set res inc dec brk spd bad  st tgt up dn flt
        add(0, 0, 0, 0, 0, 0,  80, 0, 0,   0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0,  80, 0, 1,   0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0,  20, 0, 1,   0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0,  80, 0, 2,  80, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 199, 0, 2, 199, 0, 0, 0);
        add(1, 0, 0, 1, 0, 0, 199, 0, 2, 200, 0, 0, 0);
        add(1, 0, 0, 1, 0, 0, 200, 0, 2, 200, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0,  31, 0, 2,  31, 0, 0, 0);
        add(1, 0, 0, 0, 1, 0,  31, 0, 2,  30, 0, 0, 0);
        add(1, 0, 0, 0, 1, 0,  30, 0, 2,  30, 0, 0, 0);
        add(1, 0, 0, 1, 1, 0,  30, 0, 2,  30, 0, 0, 0);
        add(1, 0, 0, 1, 0, 1,  30, 0, 3,  30, 0, 0, 0);
        add(1, 0, 0, 1, 0, 0,  30, 0, 3,  30, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0,  30, 0, 2,  30, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0,  30, 0, 2,  30, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0,  30, 0, 2,  30, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0,  30, 0, 2,  30, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0,  30, 1, 3,  30, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0,  30, 0, 3,  30, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0,  30, 0, 0,  30, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0,  30, 0, 1,  30, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 250, 0, 1,  30, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0,  80, 0, 2,  80, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0,  70, 0, 2,  80, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0,  70, 0, 2,  80, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0,  70, 0, 2,  80, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0,  70, 0, 2,  80, 1, 0, 0);
        add(1, 0, 0, 0, 0, 0,  90, 0, 2,  80, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0,  90, 0, 2,  80, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0,  90, 0, 2,  80, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0,  90, 0, 2,  80, 0, 1, 0);
        add(1, 0, 0, 0, 0, 1,  90, 0, 3,  80, 0, 0, 0);

        do_reset();
        #1;
        chk_all("reset", 0, 0, 0, 0, 0);
        cur_tgt = 0;
        foreach (tv[i]) begin
            drive(tv[i].co, tv[i].set, tv[i].res, tv[i].inc, tv[i].dec, tv[i].brk, tv[i].spd, cur_tgt);
            if (tv[i].bad) {cmp_g, cmp_eq, cmp_l} = 3'b101;
            step();
            chk_all($sformatf("vec%0d", i), tv[i].st, tv[i].tgt, tv[i].up, tv[i].dn, tv[i].flt);
            cur_tgt = tv[i].tgt;
        end

        // sustained under-speed: throttle_up every CMP_PERIOD cycles
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 80, 0);
        step();
        drive(1, 1, 0, 0, 0, 0, 80, 0);
        step();
        ups = 0; dns = 0; first_up = -1; last_up = -1; gap_ok = 1;
        for (int c = 1; c <= 12; c++) begin
            drive(1, 0, 0, 0, 0, 0, 70, 80);
            step();
            if (throttle_down) dns++;
            if (throttle_up) begin
                if (last_up >= 0 && c - last_up != PER) gap_ok = 0;
                if (first_up < 0) first_up = c;
                last_up = c;
                ups++;
            end
        end
        chk("underspeed.up_count", ups, 3);
        chk("underspeed.down_count", dns, 0);
        chk("underspeed.first_up", first_up, PER);
        chk("underspeed.spacing", gap_ok, 1);

        // reset in ACTIVE right at a sample point
        for (int c = 0; c < 3; c++) begin
            drive(1, 0, 0, 0, 0, 0, 70, 80);
            step();
        end
        chk_all("pre_rst", 2, 80, 0, 0, 0);
        rst = 1'b1;
        drive(1, 1, 0, 1, 0, 0, 70, 80);
        step();
        chk_all("rst_active", 0, 0, 0, 0, 0);
        rst = 1'b0;
        drive(1, 0, 0, 0, 0, 0, 70, 0);
        step();
        chk_all("after_rst", 1, 0, 0, 0, 0);

        // randomized run against the reference model
        do_reset();
        m_st = 0; m_tgt = 0; m_age = 0; m_up = 0; m_dn = 0; m_flt = 0;
        for (int n = 0; n < 3000; n++) begin
            int s;
            rst = ($urandom % 300) == 0;
            s = ($urandom % 3 == 0) ? int'($urandom_range(20, 210)) : m_tgt + int'($urandom_range(0, 12)) - 6;
            if (s < 0) s = 0;
            if (s > 255) s = 255;
            drive($urandom % 40 != 0, $urandom % 12 == 0, $urandom % 8 == 0, $urandom % 4 == 0,
                  $urandom % 4 == 0, $urandom % 15 == 0, s, m_tgt);
            if ($urandom % 20 == 0) drive_cmp(m_tgt, 1'b1);
            model_step();
            step();
            chk_all($sformatf("rand%0d", n), m_st, m_tgt, m_up, m_dn, m_flt);
            chk($sformatf("rand%0d.exclusive", n), int'(throttle_up && throttle_down), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cruise_speed_controller.md
CRUISE_SPEED_CONTROLLER -- requirements
Module: cruise_speed_controller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter MIN_SPEED, default 30: lowest legal target speed.
REQ-003 Parameter MAX_SPEED, default 200: highest legal target speed.
REQ-004 Parameter STEP, default 2: target increment/decrement per button pulse.
REQ-005 Parameter CMP_PERIOD, default 4: cycles between comparator samples, legal range 2..255.
REQ-006 Port clk  in  1  system clock; all state changes on its rising edge.
REQ-007 Port rst  in  1  synchronous, active-high reset.
REQ-008 Port cruise_on  in  1  master enable level.
REQ-009 Ports set_btn, resume_btn, inc_btn, dec_btn, brake  in  1 each  single-cycle pulses, already debounced.
REQ-010 Port speed  in  8  measured vehicle speed, unsigned.
REQ-011 Port target  out  8  registered target speed; drives comparator input b (speed drives input a).
REQ-012 Port cmp_en  out  1  comparator enable.
REQ-013 Ports cmp_g, cmp_eq, cmp_l  in  1 each  comparator result: speed >, =, < target.
REQ-014 Ports throttle_up, throttle_down  out  1 each  single-cycle throttle command pulses.
REQ-015 Port state  out  2  current FSM state encoding.
REQ-016 Port fault  out  1  sticky comparator-inconsistency flag.

Function
REQ-017 FSM states SHALL be IDLE=0, ARMED=1, ACTIVE=2, SUSPEND=3.
REQ-018 cruise_on=0 SHALL force IDLE on the next edge from any state; IDLE->ARMED when cruise_on=1.
REQ-019 Event priority per cycle SHALL be: brake, then cruise_on=0, then set_btn, then resume_btn, then inc/dec.
REQ-020 set_btn in ARMED, ACTIVE or SUSPEND SHALL load target<=speed and enter ACTIVE if MIN_SPEED<=speed<=MAX_SPEED; otherwise it is ignored.
REQ-021 brake in ACTIVE SHALL enter SUSPEND with target retained; brake in other states has no effect.
REQ-022 resume_btn in SUSPEND SHALL enter ACTIVE with the unchanged target; it is ignored elsewhere.
REQ-023 inc_btn in ACTIVE SHALL set target<=min(target+STEP, MAX_SPEED) using 9-bit intermediate arithmetic, no wrap-around.
REQ-024 dec_btn in ACTIVE SHALL set target<=max(target-STEP, MIN_SPEED), no underflow.
REQ-025 inc_btn and dec_btn asserted in the same cycle SHALL both be ignored.
REQ-026 cmp_en SHALL be 1 only in ACTIVE.
REQ-027 A sample counter SHALL run 0..CMP_PERIOD-1 in ACTIVE and be held at 0 in all other states; it restarts at 0 on entry to ACTIVE and on any target change.
REQ-028 At counter value CMP_PERIOD-1, cmp_l SHALL produce a one-cycle throttle_up and cmp_g a one-cycle throttle_down on the next cycle; cmp_eq produces nothing.
REQ-029 throttle_up and throttle_down SHALL never be high simultaneously and SHALL be 0 outside ACTIVE, including the cycle after leaving ACTIVE.
REQ-030 At a sample point, a one-hot violation of {cmp_g, cmp_eq, cmp_l} SHALL set fault=1, suppress throttle output and enter SUSPEND.
REQ-031 fault SHALL clear only in IDLE.

Reset
REQ-032 rst SHALL force: state=IDLE, target=0, counter=0, cmp_en=0, throttle_up=0, throttle_down=0, fault=0.
REQ-033 rst SHALL override every other input, including mid-operation in ACTIVE; no throttle pulse is emitted in the reset cycle or the cycle after it.

Structure
REQ-034 Shared package cruise_pkg SHALL hold the state encoding and default MIN_SPEED/MAX_SPEED/STEP constants.
REQ-035 The sample counter SHALL be a sub-module named sample_timer with inputs clk, rst, clear, run, and output tick.
REQ-036 The block SHALL instantiate no comparator; it connects to the existing 8-bit comparator externally.

Verification
REQ-037 cruise_on=1, speed=80, set_btn -> state=ACTIVE, target=80, cmp_en=1 on the next cycle.
REQ-038 ACTIVE, target=80, speed=70 (cmp_l=1) for 12 cycles -> exactly 3 throttle_up pulses spaced 4 cycles apart, no throttle_down.
REQ-039 target=199, inc_btn -> target=200; inc_btn again -> 200; target=31, dec_btn -> 30.
REQ-040 ACTIVE, brake together with inc_btn -> SUSPEND, target unchanged, cmp_en=0; resume_btn -> ACTIVE, same target.
REQ-041 ACTIVE, cmp_g=cmp_l=1 at a sample point -> fault=1, SUSPEND, no throttle pulse; cruise_on=0 -> IDLE, fault=0.
REQ-042 set_btn with speed=20 -> no state change; rst asserted in ACTIVE -> all outputs at reset values on the next cycle.
